instr_loader: RTL

Write-side companion to the instruction ROM: accepts a program as a little-endian byte stream over a valid/ready handshake, assembles W-bit instruction words, and writes them sequentially into the instruction memory array starting at address 0. It holds the CPU stalled while loading and pulses `done` when the last word is written. It sits between the bench or host byte source and the instruction memory write port, replacing file-based preload when a program is delivered at run time.

---
 rtl/instr_loader_pkg.sv | 22 ++
 rtl/instr_loader_if.sv | 36 +++
 rtl/instr_loader_word_assembler.sv | 54 +++++
 rtl/instr_loader.sv | 133 +++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction memory path.
// Contents:
//   loader_state_t  - sequencing states of the program loader
//   bytes_per_word  - number of stream bytes needed to build one W-bit word
//   INSTR_A/INSTR_W - default address/instruction widths, shared with the ROM/RAM
package instr_pkg;

    localparam int INSTR_A = 8;
    localparam int INSTR_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    function automatic int bytes_per_word(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Signals:
//   byteValid/byteData/byteReady - little-endian program byte stream (valid/ready)
//   wrEn/wrAddress/wrData        - instruction memory write strobe, address, word
// Modports:
//   slave  - the loader: consumes bytes, drives the memory write port
//   master - the host/byte source: supplies bytes, observes the write port
interface instr_loader_if #(
    parameter int A = 8,
    parameter int W = 9
);
    logic         byteValid;
    logic [7:0]   byteData;
    logic         byteReady;
    logic         wrEn;
    logic [A-1:0] wrAddress;
    logic [W-1:0] wrData;

    modport slave (
        input  byteValid,
        input  byteData,
        output byteReady,
        output wrEn,
        output wrAddress,
        output wrData
    );

    modport master (
        output byteValid,
        output byteData,
        input  byteReady,
        input  wrEn,
        input  wrAddress,
        input  wrData
    );
endinterface

// File: rtl/instr_loader_word_assembler.sv
// Builds one W-bit instruction from a little-endian byte sequence.
// Ports:
//   CLK, reset  - clock, synchronous active-high reset
//   clear       - restart assembly: byte index and word register to zero
//   load        - insert byte_data at the current byte position and advance
//   byte_data   - incoming program byte
//   word        - assembled (registered) instruction word
//   last        - current byte position is the final byte of a word
module word_assembler
    import instr_pkg::*;
#(
    parameter int W = INSTR_W
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [7:0]   byte_data,
    output logic [W-1:0] word,
    output logic         last
);

    localparam int BYTES = bytes_per_word(W);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     word_q;
    logic [W-1:0]     word_n;

    // Insert per bit so that bits of the final byte above W simply have no
    // destination and are dropped.
    always_comb begin
        word_n = word_q;
        for (int b = 0; b < W; b++) begin
            if (idx_q == IDX_W'(b / 8)) begin
                word_n[b] = byte_data[b % 8];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset || clear) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (load) begin
            word_q <= word_n;
            idx_q  <= last ? '0 : idx_q + 1'b1;
        end
    end

    assign last = (idx_q == IDX_W'(BYTES - 1));
    assign word = word_q;

endmodule

// File: rtl/instr_loader.sv
// Run-time program loader for the instruction memory. Takes a byte stream,
// assembles instruction words and writes them to addresses 0..count-1 while
// holding the CPU stalled; pulses done after the last write.
// Ports:
//   CLK        - system clock, rising edge
//   reset      - synchronous active-high, returns to IDLE and aborts any load
//   start      - one-cycle load request, honoured only in IDLE
//   wordCount  - words to load, sampled with start, clamped to 2**A
//   bus        - byte stream in, instruction memory write port out
//   busy       - loader active (any state but IDLE)
//   cpuHold    - same as busy, stalls the CPU program counter
//   done       - one-cycle pulse at the end of a load
//
// state | meaning
// IDLE  | waiting for start, no bytes accepted
// RECV  | accepting bytes of the current word
// WRITE | word complete, memory write strobe asserted
// DONE  | load finished, done pulse
module instr_loader
    import instr_pkg::*;
#(
    parameter int A = INSTR_A,
    parameter int W = INSTR_W
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic           start,
    input  logic [A:0]     wordCount,
    instr_loader_if.slave  bus,
    output logic           busy,
    output logic           cpuHold,
    output logic           done
);

    localparam logic [A:0] MAX_COUNT = (A + 1)'(1) << A;

    loader_state_t state;
    logic          byte_ready;
    logic          wr_en;
    logic [A-1:0]  addr;
    logic [A:0]    count_lat;
    logic [A:0]    count_clamped;
    logic          accept;
    logic          asm_clear;
    logic          asm_last;
    logic [W-1:0]  asm_word;

    assign count_clamped = (wordCount > MAX_COUNT) ? MAX_COUNT : wordCount;

    // byte_ready is only ever set in RECV, so this also gates on state.
    assign accept    = bus.byteValid && byte_ready;
    assign asm_clear = (state == WRITE) || ((state == IDLE) && start);

    word_assembler #(
        .W(W)
    ) u_word_assembler (
        .CLK       (CLK),
        .reset     (reset),
        .clear     (asm_clear),
        .load      (accept),
        .byte_data (bus.byteData),
        .word      (asm_word),
        .last      (asm_last)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            addr       <= '0;
            count_lat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count_lat <= count_clamped;
                        addr      <= '0;
                        busy      <= 1'b1;
                        if (count_clamped == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= RECV;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (accept && asm_last) begin
                        state      <= WRITE;
                        byte_ready <= 1'b0;
                        wr_en      <= 1'b1;
                    end
                end
                WRITE: begin
                    wr_en <= 1'b0;
                    // Compare in A+1 bits so a full 2**A load ends at the top
                    // address instead of wrapping.
                    if ({1'b0, addr} == count_lat - (A + 1)'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        addr       <= addr + 1'b1;
                        state      <= RECV;
                        byte_ready <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    wr_en      <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byteReady = byte_ready;
    assign bus.wrEn      = wr_en;
    assign bus.wrAddress = addr;
    assign bus.wrData    = asm_word;
    assign cpuHold       = busy;

endmodule
